// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU plus iterative radix-2 multiply/divide unit
// with HI/LO registers.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   a, b, f             ALU operands and op select (also the MD operands)
//   y, cout, zero       combinational ALU result, adder carry, y == 0
//   ovf                 signed ADD/SUB overflow (only when ALU_OVF_EN is defined)
//   md_start, md_op     launch MULT/MULTU/DIV/DIVU on a, b
//   md_abort            cancel an in-flight MD operation
//   hilo_we, hilo_wdata direct HI/LO writes (MTHI/MTLO)
//   md_busy, md_done    MD engine iterating / one-cycle result pulse
//   hi, lo              HI and LO registers
//
// Configuration macro: ALU_OVF_EN adds the ovf output port.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             md_abort,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ---------------- ALU path ----------------
    logic [WIDTH-1:0] bb_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] y_s;
    logic             cout_s;
    logic             ovf_add_s;

    // Shared adder with optional inversion of b; op decode selects the result.
    always_comb begin
        bb_s             = f[2] ? ~b : b;
        {cout_s, sum_s}  = {1'b0, a} + {1'b0, bb_s} + {{WIDTH{1'b0}}, f[2]};
        ovf_add_s        = (a[WIDTH-1] == bb_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        y_s              = {WIDTH{1'b0}};
        case (f[1:0])
            2'b00:   y_s = a & bb_s;
            2'b01:   y_s = a | bb_s;
            2'b10:   y_s = sum_s;
            2'b11: begin
                // 011 is plain XOR; 111 is signed less-than corrected for overflow.
                if (f[2]) begin
                    y_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_add_s};
                end else begin
                    y_s = a ^ b;
                end
            end
            default: y_s = {WIDTH{1'b0}};
        endcase
    end

    assign y    = y_s;
    assign cout = cout_s;
    assign zero = (y_s == {WIDTH{1'b0}});
`ifdef ALU_OVF_EN
    assign ovf  = (f[1:0] == 2'b10) && ovf_add_s;
`endif

    // ---------------- MD engine ----------------
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q;      // current op is a divide
    logic               dz_q;       // divide by zero: skip iteration
    logic [1:0]         sgn_q;      // [0] product/quotient negative, [1] remainder negative
    logic [WIDTH-1:0]   m_q;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] p_q;        // {acc/remainder, multiplier/quotient}
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               signed_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_sh_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Operand magnitudes at launch, one shift-add / restoring-subtract step,
    // and sign fix-up of the final step's value.
    always_comb begin
        signed_s   = ~md_op[0];
        abs_a_s    = (signed_s && a[WIDTH-1]) ? -a : a;
        abs_b_s    = (signed_s && b[WIDTH-1]) ? -b : b;
        mul_sum_s  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        div_sh_s   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff_s = div_sh_s - {1'b0, m_q};
        if (!div_q) begin
            step_s = {mul_sum_s, p_q[WIDTH-1:1]};
        end else if (!div_diff_s[WIDTH]) begin
            step_s = {div_diff_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            step_s = {div_sh_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end
        prod_s   = sgn_q[0] ? -step_s : step_s;
        quot_s   = sgn_q[0] ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
        rem_s    = sgn_q[1] ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
        res_hi_s = div_q ? rem_s  : prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = div_q ? quot_s : prod_s[WIDTH-1:0];
    end

    // MD control FSM, datapath registers and HI/LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            sgn_q   <= 2'b00;
            m_q     <= {WIDTH{1'b0}};
            p_q     <= {(2*WIDTH){1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (md_start && !md_abort) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(WIDTH-1);
                        div_q   <= md_op[1];
                        dz_q    <= md_op[1] && (b == {WIDTH{1'b0}});
                        sgn_q   <= {signed_s && a[WIDTH-1], signed_s && (a[WIDTH-1] ^ b[WIDTH-1])};
                        m_q     <= abs_b_s;
                        // Divide by zero keeps the raw dividend so it can be returned in HI.
                        p_q     <= {{WIDTH{1'b0}}, (md_op[1] && (b == {WIDTH{1'b0}})) ? a : abs_a_s};
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (hilo_we[1]) hi_q <= hilo_wdata;
                        if (hilo_we[0]) lo_q <= hilo_wdata;
                    end
                end
                S_RUN: begin
                    if (md_abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (dz_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= p_q[WIDTH-1:0];
                        lo_q    <= {WIDTH{1'b1}};
                    end else begin
                        p_q <= step_s;
                        if (cnt_q == {CW{1'b0}}) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            hi_q    <= res_hi_s;
                            lo_q    <= res_lo_s;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
    logic        clk;
    logic        reset_n;
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [31:0] y;
    logic        cout, zero;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_abort;
    logic [1:0]  hilo_we;
    logic [31:0] hilo_wdata;
    logic        md_busy, md_done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .f(f),
        .y(y), .cout(cout), .zero(zero),
`ifdef ALU_OVF_EN
        .ovf(ovf),
`endif
        .md_start(md_start), .md_op(md_op), .md_abort(md_abort),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        logic        cout;
        logic        zero;
        logic        ovf;
    } alu_vec_t;

    alu_vec_t vecs[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference ALU from plain arithmetic on the op meaning.
    task automatic alu_model(input logic [31:0] x, input logic [31:0] z, input logic [2:0] op,
                             output logic [31:0] ry, output logic rc, output logic rv);
        longint sx, sz, r;
        logic [32:0] wide;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        rv = 1'b0;
        case (op)
            3'b000: ry = x & z;
            3'b001: ry = x | z;
            3'b010: begin ry = x + z; r = sx + sz; rv = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'b011: ry = x ^ z;
            3'b100: ry = x & ~z;
            3'b101: ry = x | ~z;
            3'b110: begin ry = x - z; r = sx - sz; rv = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            default: ry = (sx < sz) ? 32'd1 : 32'd0;
        endcase
        if (op[2]) begin
            rc = (x >= z);
        end else begin
            wide = {1'b0, x} + {1'b0, z};
            rc = wide[32];
        end
    endtask

    // Reference MD result {hi, lo}.
    function automatic logic [63:0] md_model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] z);
        longint sx, sz, q, r;
        logic [63:0] ux, uz;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        ux = {32'd0, x};
        uz = {32'd0, z};
        case (op)
            2'b00: md_model = 64'(sx * sz);
            2'b01: md_model = ux * uz;
            default: begin
                if (z == 32'd0) begin
                    md_model = {x, 32'hFFFFFFFF};
                end else if (op == 2'b10) begin
                    q = sx / sz;
                    r = sx % sz;
                    md_model = {r[31:0], q[31:0]};
                end else begin
                    md_model = {x % z, x / z};
                end
            end
        endcase
    endfunction

    // Called at a negedge; launches an op and returns at the negedge where md_done is seen.
    task automatic run_md(input string nm, input logic [1:0] op, input logic [31:0] x, input logic [31:0] z,
                          input logic [31:0] eh, input logic [31:0] el, input int lat);
        int cyc;
        int busy;
        md_op = op; a = x; b = z; md_start = 1'b1;
        cyc = 0; busy = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                md_start = 1'b0;
                a = $urandom; b = $urandom;
            end
            if (md_busy) busy++;
        end while (!md_done && cyc < 100);
        check({nm, " latency"}, 64'(cyc), 64'(lat));
        check({nm, " busy cycles"}, 64'(busy), 64'(lat - 1));
        check({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
        check({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        logic [31:0] ey;
        logic        ec, ev;
        logic [63:0] m;
        logic [1:0]  op;
        logic [31:0] x, z;
        int          cyc;

        vecs[0]  = '{32'd7,        32'd5,        3'b110, 32'd2,        1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h80000000, 32'd1,        3'b111, 32'd1,        1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h12345678, 32'h12345678, 3'b011, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 32'hF0FFF0FF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'd5,        32'd7,        3'b111, 32'd1,        1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'd7,        32'd5,        3'b111, 32'd0,        1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'd3,        32'd5,        3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h7FFFFFFF, 32'd1,        3'b010, 32'h80000000, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b1; a = 32'd0; b = 32'd0; f = 3'b000;
        md_start = 1'b0; md_op = 2'b00; md_abort = 1'b0; hilo_we = 2'b00; hilo_wdata = 32'd0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, md_busy}, 64'd0);
        check("reset done", {63'd0, md_done}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ALU vector table
        for (int i = 0; i < 13; i++) begin
            a = vecs[i].a; b = vecs[i].b; f = vecs[i].f;
            #1;
            check($sformatf("alu vec%0d y", i), {32'd0, y}, {32'd0, vecs[i].y});
            check($sformatf("alu vec%0d cout", i), {63'd0, cout}, {63'd0, vecs[i].cout});
            check($sformatf("alu vec%0d zero", i), {63'd0, zero}, {63'd0, vecs[i].zero});
`ifdef ALU_OVF_EN
            check($sformatf("alu vec%0d ovf", i), {63'd0, ovf}, {63'd0, vecs[i].ovf});
`endif
        end

        // Randomized ALU against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = (i % 5 == 0) ? a : $urandom;
            if (i % 7 == 0) a = 32'h80000000;
            f = 3'($urandom_range(0, 7));
            #1;
            alu_model(a, b, f, ey, ec, ev);
            check($sformatf("alu rnd%0d y", i), {32'd0, y}, {32'd0, ey});
            check($sformatf("alu rnd%0d cout", i), {63'd0, cout}, {63'd0, ec});
            check($sformatf("alu rnd%0d zero", i), {63'd0, zero}, {63'd0, (ey == 32'd0)});
`ifdef ALU_OVF_EN
            check($sformatf("alu rnd%0d ovf", i), {63'd0, ovf}, {63'd0, ev});
`endif
        end
        @(negedge clk);

        // Hand-written MD corner cases
        run_md("mult -3*7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
        @(negedge clk);
        check("done one-cycle pulse", {63'd0, md_done}, 64'd0);
        run_md("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        // back-to-back launch in the DONE cycle
        run_md("divu 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 33);
        @(negedge clk);
        run_md("divu by zero", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 2);
        @(negedge clk);
        run_md("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
        run_md("multu max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 33);

        // HI write in the DONE cycle lands after the result
        hilo_we = 2'b10; hilo_wdata = 32'hDEADBEEF;
        @(negedge clk);
        hilo_we = 2'b00;
        check("done-cycle write hi", {32'd0, hi}, {32'd0, 32'hDEADBEEF});
        check("done-cycle write lo", {32'd0, lo}, 64'd1);

        // MTHI/MTLO in IDLE
        hilo_we = 2'b11; hilo_wdata = 32'hCAFEF00D;
        @(negedge clk);
        hilo_we = 2'b00;
        check("mthi", {32'd0, hi}, {32'd0, 32'hCAFEF00D});
        check("mtlo", {32'd0, lo}, {32'd0, 32'hCAFEF00D});

        // Abort in RUN; LO write during RUN is dropped
        md_op = 2'b00; a = 32'd9; b = 32'd9; md_start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            md_start = 1'b0;
            hilo_we = (k == 5) ? 2'b01 : 2'b00;
            hilo_wdata = 32'h11111111;
            if (md_busy) cyc++;
        end
        hilo_we = 2'b00;
        check("busy before abort", 64'(cyc), 64'd10);
        md_abort = 1'b1;
        @(negedge clk);
        md_abort = 1'b0;
        check("busy after abort", {63'd0, md_busy}, 64'd0);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_done) cyc++;
        end
        check("no done after abort", 64'(cyc), 64'd0);
        check("abort keeps hi", {32'd0, hi}, {32'd0, 32'hCAFEF00D});
        check("abort keeps lo", {32'd0, lo}, {32'd0, 32'hCAFEF00D});

        // Abort together with start in IDLE launches nothing
        md_start = 1'b1; md_abort = 1'b1; a = 32'd5; b = 32'd0; md_op = 2'b11;
        @(negedge clk);
        md_start = 1'b0; md_abort = 1'b0;
        check("abort+start busy", {63'd0, md_busy}, 64'd0);
        @(negedge clk);
        check("abort+start done", {63'd0, md_done}, 64'd0);
        check("abort+start lo", {32'd0, lo}, {32'd0, 32'hCAFEF00D});

        // Randomized MD ops against the reference model, some back-to-back
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            x = $urandom;
            z = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 8 == 0) x = 32'h80000000;
            if (i % 3 == 1) z = -z;
            m = md_model(op, x, z);
            run_md($sformatf("md rnd%0d", i), op, x, z, m[63:32], m[31:0],
                   (op[1] && z == 32'd0) ? 2 : 33);
            if (i % 2 == 0) @(negedge clk);
        end

        // Asynchronous reset in the middle of RUN
        md_op = 2'b01; a = 32'h12345678; b = 32'h9ABCDEF0; md_start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            md_start = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        check("async reset hi", {32'd0, hi}, 64'd0);
        check("async reset lo", {32'd0, lo}, 64'd0);
        check("async reset busy", {63'd0, md_busy}, 64'd0);
        check("async reset done", {63'd0, md_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
